// File: rtl/axi_full_s_ram_if.sv
// AXI4-full bus bundle (no SIZE/BURST/LOCK/CACHE/PROT/QOS/USER) between a burst master and the RAM slave.
// Every channel uses valid/ready: a beat transfers on a rising edge where both are high; valid never waits on ready.
interface axi_full_s_ram_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_full_s_ram.sv
// AXI4-full slave over a word RAM: one INCR write burst and one INCR read burst in flight,
// with independent write and read FSMs so readback can overlap an open write.
module axi_full_s_ram #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_MEM_DEPTH      = 1024
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi_full_s_ram_if.slave       s_axi,
  output logic [1:0]            w_state_dbg,
  output logic                  r_state_dbg
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(C_S_MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state;
  r_state_e r_state;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_S_MEM_DEPTH];

  logic [IDX_W-1:0] aw_idx, ar_idx, w_idx, r_idx, r_idx_next;
  logic [7:0]       w_len, w_cnt, r_len, r_cnt;
  logic             w_err, w_beat_err;
  logic             aw_fire, w_fire, ar_fire, r_fire;

  logic [C_S_AXI_ID_WIDTH-1:0] bid_q, rid_q;
  logic                        awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
  logic [1:0]                  bresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // Base-address bits above the RAM and sub-word byte offsets carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:LSB+IDX_W], s_axi.awaddr[LSB-1:0],
                              s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:LSB+IDX_W], s_axi.araddr[LSB-1:0]};

  assign aw_idx     = s_axi.awaddr[LSB+IDX_W-1:LSB];
  assign ar_idx     = s_axi.araddr[LSB+IDX_W-1:LSB];
  assign r_idx_next = r_idx + IDX_ONE;

  assign aw_fire = s_axi.awvalid && awready_q;
  assign w_fire  = s_axi.wvalid && wready_q;
  assign ar_fire = s_axi.arvalid && arready_q;
  assign r_fire  = rvalid_q && s_axi.rready;

  // A beat is malformed when WLAST disagrees with the beat counter in either direction.
  assign w_beat_err = s_axi.wlast ^ (w_cnt == w_len);

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rvalid  = rvalid_q;

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  always_ff @(posedge s_axi_aclk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      w_idx     <= '0;
      w_len     <= 8'd0;
      w_cnt     <= 8'd0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_axi.awid;
            w_idx     <= aw_idx;
            w_len     <= s_axi.awlen;
            w_cnt     <= 8'd0;
            w_err     <= 1'b0;
            w_state   <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + IDX_ONE;
            w_cnt <= w_cnt + 8'd1;
            if (w_beat_err) w_err <= 1'b1;
            // The beat count, not WLAST, closes the burst.
            if (w_cnt == w_len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      r_idx     <= '0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= mem[ar_idx];
            rlast_q   <= (s_axi.arlen == 8'd0);
            rid_q     <= s_axi.arid;
            r_idx     <= ar_idx;
            r_len     <= s_axi.arlen;
            r_cnt     <= 8'd0;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          // Prefetching the next word on each handshake keeps RVALID high with no bubbles.
          if (r_fire) begin
            if (r_cnt == r_len) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              rdata_q <= mem[r_idx_next];
              r_idx   <= r_idx_next;
              r_cnt   <= r_cnt + 8'd1;
              rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_full_s_ram.sv
// Bench for axi_full_s_ram: bursts are driven through tasks, read data is checked against a
// byte-strobe memory model through an expected queue.
module tb_axi_full_s_ram;
  localparam int ID_W   = 1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LSB    = 2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BASE = 32'h4000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] w_state_dbg;
  logic       r_state_dbg;

  axi_full_s_ram_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_full_s_ram #(
    .C_S_AXI_ID_WIDTH  (ID_W),
    .C_S_AXI_ADDR_WIDTH(ADDR_W),
    .C_S_AXI_DATA_WIDTH(DATA_W),
    .C_S_MEM_DEPTH     (DEPTH)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi        (bus),
    .w_state_dbg  (w_state_dbg),
    .r_state_dbg  (r_state_dbg)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_master();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, bus.awready, 0);
    check({tag, "_wready"},  bus.wready, 0);
    check({tag, "_bvalid"},  bus.bvalid, 0);
    check({tag, "_bresp"},   bus.bresp, 0);
    check({tag, "_arready"}, bus.arready, 0);
    check({tag, "_rvalid"},  bus.rvalid, 0);
    check({tag, "_rlast"},   bus.rlast, 0);
    check({tag, "_rdata"},   bus.rdata, 0);
  endtask

  // abort_at >= 0 asserts reset in place of that beat and returns with the burst open.
  task automatic write_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input int len, input logic [DATA_W-1:0] base,
                             input logic [STRB_W-1:0] strb, input int last_at,
                             input logic [1:0] exp_resp, input int abort_at);
    int start;
    int n;
    start = int'((addr >> LSB) % DEPTH);
    @(posedge clk); #1;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
    if (!bus.awready) begin check("aw_timeout", 0, 1); clear_master(); return; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        clear_master();
        return;
      end
      bus.wvalid = 1'b1;
      bus.wdata  = base + DATA_W'(i);
      bus.wstrb  = strb;
      bus.wlast  = (i == last_at);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.wready && n < 50);
      if (!bus.wready) begin check("w_timeout", i, len + 1); clear_master(); return; end
      @(posedge clk);
      for (int b = 0; b < STRB_W; b++)
        if (strb[b]) model[(start + i) % DEPTH][8*b +: 8] = bus.wdata[8*b +: 8];
      #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    check("w_closed", bus.wready, 0);
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, exp_resp);
    check("bid", bus.bid, id);
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    check("b_done", bus.bvalid, 0);
    check("aw_rearm", bus.awready, 1);
  endtask

  // stall=1 drives RREADY as 1,0,0,1,0,0,... and checks RDATA holds through each stall.
  task automatic read_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input int len, input bit stall);
    int start;
    int n;
    int beat;
    int k;
    bit held;
    logic [DATA_W-1:0] held_data;
    logic [DATA_W-1:0] exp;
    start = int'((addr >> LSB) % DEPTH);
    exp_q.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back(model[(start + i) % DEPTH]);
    @(posedge clk); #1;
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
    if (!bus.arready) begin check("ar_timeout", 0, 1); clear_master(); return; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    beat = 0; k = 0; held = 1'b0; held_data = '0;
    while (beat <= len && k < 400) begin
      @(negedge clk);
      if (k == 0) check("first_rvalid", bus.rvalid, 1);
      if (held) check("r_hold", bus.rdata, held_data);
      if (!stall) check("r_no_bubble", bus.rvalid, 1);
      if (bus.rvalid && bus.rready) begin
        exp = exp_q.pop_front();
        check("rdata", bus.rdata, exp);
        check("rlast", bus.rlast, 64'(beat == len));
        check("rid", bus.rid, id);
        check("rresp", bus.rresp, 0);
        beat++;
        held = 1'b0;
      end else if (bus.rvalid) begin
        held = 1'b1;
        held_data = bus.rdata;
      end
      @(posedge clk); #1;
      k++;
      bus.rready = stall ? (k % 3 == 0) : 1'b1;
    end
    bus.rready = 1'b0;
    if (beat <= len) check("r_timeout", beat, len + 1);
    @(negedge clk);
    check("r_done", bus.rvalid, 0);
    check("ar_rearm", bus.arready, 1);
  endtask

  initial begin
    clear_master();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    check("rst_wstate", w_state_dbg, 0);
    check("rst_rstate", r_state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready", bus.awready, 1);
    check("rel_arready", bus.arready, 1);

    // 17-beat burst, full readback, then stalled readback
    write_burst(1'b1, BASE, 16, 32'd1, 4'hF, 16, 2'b00, -1);
    read_burst(1'b1, BASE, 16, 1'b0);
    read_burst(1'b0, BASE, 16, 1'b1);

    // early WLAST flags SLVERR but all beats land; the next burst is clean
    write_burst(1'b0, BASE + 32'h100, 7, 32'h100, 4'hF, 4, 2'b10, -1);
    read_burst(1'b0, BASE + 32'h100, 7, 1'b0);
    write_burst(1'b1, BASE + 32'h100, 7, 32'h200, 4'hF, 7, 2'b00, -1);
    read_burst(1'b1, BASE + 32'h100, 7, 1'b1);

    // byte strobes over a preset word
    write_burst(1'b0, BASE, 0, 32'hFFFF_FFFF, 4'hF, 0, 2'b00, -1);
    write_burst(1'b0, BASE, 0, 32'h0, 4'b0101, 0, 2'b00, -1);
    read_burst(1'b1, BASE, 0, 1'b0);
    check("strb_word", exp_q.size(), 0);

    // index wrap from DEPTH-1 to 0
    write_burst(1'b1, BASE + 32'((DEPTH - 2) * 4), 3, 32'hA, 4'hF, 3, 2'b00, -1);
    read_burst(1'b0, BASE + 32'((DEPTH - 2) * 4), 3, 1'b0);
    read_burst(1'b1, BASE, 1, 1'b1);

    // reset in the middle of a write burst
    write_burst(1'b1, BASE + 32'(100 * 4), 7, 32'h500, 4'hF, 7, 2'b00, 3);
    #1;
    check_all_zero("abort");
    check("abort_bid", bus.bid, 0);
    @(negedge clk);
    check("abort_hold_awready", bus.awready, 0);
    check("abort_hold_bvalid", bus.bvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_awready", bus.awready, 1);
    check("abort_no_b", bus.bvalid, 0);
    write_burst(1'b0, BASE + 32'(200 * 4), 3, 32'h600, 4'hF, 3, 2'b00, -1);
    read_burst(1'b1, BASE + 32'(100 * 4), 2, 1'b0);
    read_burst(1'b0, BASE + 32'(200 * 4), 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
